bus_memory_responder: RTL
=========================

# bus_memory_responder

Shared main-memory responder for the three-processor MESI snooping system: the memory end of the coherence bus that the processor cache nodes drive. It decodes read-miss, write-miss and invalidate messages on the bus, returns the requested block on `data_mem` after a fixed latency, and commits write-back blocks into a 16-entry memory array indexed by tag. It sits beside the three processor nodes and takes the OR-combined bus and write-back signals from them.

## Interface

- `READ_LATENCY`, default 2: cycles from request capture to `data_mem` valid; legal range 1–15.
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low.
- `bus_in` input 16: bus message.
  - [15:14] message: 00 read miss, 01 write miss, 10 invalidate, 11 reserved.
  - [13:10] tag.
  - All-zero means no request.
- `wb` input 1: write-back request level from any processor; held high until the issuing instruction ends.
- `wb_block` input 16: block being written back, formatted as [15:12] tag, [11:10] state, [9:0] data.
- `data_mem` output 16: response block, formatted as {tag, 2'b10, mem[tag]}; 0 when no response is being driven.
- `mem_valid` output 1: high while `data_mem` carries a response.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `wb_count` output 8: count of committed write-backs; saturates at 255.

## Operation

- Memory array: 16 × 10 bits, indexed by tag. Reset loads mem[t] = {6'b0, t}.
- Write-back commit:
  - Occurs on a rising edge of `wb` only. A registered `wb_q` is kept, and commit happens when wb & !wb_q.
  - Commit writes mem[wb_block[15:12]] ← wb_block[9:0] and increments `wb_count` (saturating).
  - Commit is independent of FSM state.
- FSM states: IDLE, WAIT, RESP, INV.
  - IDLE:
    - If bus_in ≠ 0 and message ∈ {00, 01}: capture the tag, load the latency counter with READ_LATENCY−1, and go to WAIT. If READ_LATENCY = 1, go directly to RESP.
    - If message = 10: capture bus_in and go to INV.
    - If message = 11: ignore and stay in IDLE.
  - WAIT: decrement the counter; when it reaches 0, go to RESP and register data_mem = {tag, 2'b10, mem[tag]}.
  - RESP:
    - Hold `data_mem` and `mem_valid` = 1.
    - Exit to IDLE, clearing `data_mem` and `mem_valid`, when bus_in = 0 or bus_in ≠ the captured request.
    - A changed request is not accepted in the same cycle; it is accepted from IDLE on the next edge.
  - INV: no data is driven and memory is not modified. Exit to IDLE when bus_in changes or clears.
- A write miss does not modify memory; the new data reaches memory only through a later write-back.
- Forwarding: if a write-back commit to the same tag occurs on the edge that registers `data_mem`, the response carries the write-back data.

## Timing

- Reset (asynchronous, any time including mid-request):
  - FSM → IDLE; `data_mem` = 0, `mem_valid` = 0, `busy` = 0, `wb_count` = 0.
  - `wb_q` = 0, so a `wb` still high after reset deasserts counts as a new edge.
  - Memory array reinitialised.
- Request sampled at edge N in IDLE → `mem_valid` high after edge N+READ_LATENCY.
- `busy` rises after edge N.
- `mem_valid` falls one cycle after bus_in clears or changes; `busy` falls at the same time.
- Minimum spacing between two accepted requests is READ_LATENCY+2 cycles.
- A write-back edge and a request in the same cycle: the write commits at that edge. A request to the same tag returns the new data, because the array read occurs at least 1 edge later or is forwarded.
- Two write-back rising edges to the same tag: last one wins. `wb_count` counts both.

## Test plan

- After reset, with READ_LATENCY = 2: bus_in = 16'h2800 (read miss, tag 1010) at edge 0 → `data_mem` = 16'hA80A with `mem_valid` = 1 after edge 2. Clearing bus_in → `data_mem` = 0 and `busy` = 0 one cycle later.
- Raise `wb` with wb_block = 16'hBC2A, then issue bus_in = 16'h6C00 (write miss, tag 1011) → `data_mem` = 16'hB82A and `wb_count` = 1.
- Hold `wb` high for 5 cycles → `wb_count` increments once. Drop and re-raise `wb` → `wb_count` = 2.
- bus_in = 16'h8C00 (invalidate) → `busy` = 1, `mem_valid` stays 0, memory unchanged (a subsequent read of tag 1011 returns the original data).
- Assert `reset` low while in WAIT → all outputs 0 immediately. After release, a new read completes in READ_LATENCY cycles.
- bus_in changed directly from a read of tag 1010 to a read of tag 1100 while in RESP → one IDLE cycle, then a fresh response {1100, 10, mem[12]}.

Source files
------------

// File: rtl/bus_memory_responder_if.sv
// Coherence-bus bundle between the processor nodes and the memory responder.
// The processor side (master) drives requests and write-backs; the memory
// side (slave) returns response blocks and status.
interface bus_memory_responder_if;
    logic [15:0] bus_in;
    logic        wb;
    logic [15:0] wb_block;
    logic [15:0] data_mem;
    logic        mem_valid;
    logic        busy;
    logic [7:0]  wb_count;

    modport master (
        output bus_in,
        output wb,
        output wb_block,
        input  data_mem,
        input  mem_valid,
        input  busy,
        input  wb_count
    );

    modport slave (
        input  bus_in,
        input  wb,
        input  wb_block,
        output data_mem,
        output mem_valid,
        output busy,
        output wb_count
    );
endinterface

// File: rtl/bus_memory_responder.sv
// Shared main-memory responder on the MESI snooping bus.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request in flight; watching bus_in for a new message
// WAIT  | read/write miss captured; latency counter running down
// RESP  | data_mem/mem_valid driven until bus_in clears or changes
// INV   | invalidate seen; nothing driven, wait for bus_in to move on
//
// Write-back commits run independently of the FSM on each rising edge of wb.
module bus_memory_responder #(
    parameter int READ_LATENCY = 2
) (
    input logic               clock,
    input logic               reset,
    bus_memory_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        INV  = 2'd3
    } state_t;

    localparam logic [1:0] MSG_READ_MISS  = 2'b00;
    localparam logic [1:0] MSG_WRITE_MISS = 2'b01;
    localparam logic [1:0] MSG_INVALIDATE = 2'b10;
    // Counter is loaded with latency-1 at capture and WAIT exits on zero,
    // so a READ_LATENCY of 1 still spends exactly one edge in WAIT and the
    // response appears after capture edge + READ_LATENCY in every case.
    localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  tag_q;
    logic [15:0] req_q;
    logic [15:0] data_q;
    logic        valid_q;
    logic        busy_q;
    logic        wb_q;
    logic [7:0]  wb_count_q;
    logic [9:0]  mem [16];

    logic        commit;
    logic [3:0]  wb_tag;
    logic [9:0]  wb_data;
    logic [9:0]  rd_data;
    logic [1:0]  msg;

    assign commit  = bus.wb & ~wb_q;
    assign wb_tag  = bus.wb_block[15:12];
    assign wb_data = bus.wb_block[9:0];
    assign msg     = bus.bus_in[15:14];

    // A write-back landing on the same edge as the array read is forwarded.
    assign rd_data = (commit && (wb_tag == tag_q)) ? wb_data : mem[tag_q];

    // Write-back edge detect, memory array commit and saturating commit count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_q       <= 1'b0;
            wb_count_q <= 8'd0;
            for (int t = 0; t < 16; t++) begin
                mem[t] <= 10'(t);
            end
        end else begin
            wb_q <= bus.wb;
            if (commit) begin
                mem[wb_tag] <= wb_data;
                if (wb_count_q != 8'hFF) begin
                    wb_count_q <= wb_count_q + 8'd1;
                end
            end
        end
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            tag_q   <= 4'd0;
            req_q   <= 16'd0;
            data_q  <= 16'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.bus_in != 16'd0) begin
                        if ((msg == MSG_READ_MISS) || (msg == MSG_WRITE_MISS)) begin
                            tag_q  <= bus.bus_in[13:10];
                            req_q  <= bus.bus_in;
                            cnt    <= CNT_LOAD;
                            state  <= WAIT;
                            busy_q <= 1'b1;
                        end else if (msg == MSG_INVALIDATE) begin
                            req_q  <= bus.bus_in;
                            state  <= INV;
                            busy_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        data_q  <= {tag_q, 2'b10, rd_data};
                        valid_q <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // A captured request is never zero, so this also covers a clear.
                    if (bus.bus_in != req_q) begin
                        data_q  <= 16'd0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                INV: begin
                    if (bus.bus_in != req_q) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_mem  = data_q;
    assign bus.mem_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.wb_count  = wb_count_q;

endmodule
